// File: rtl/product_accumulator_pkg.sv
// Shared widths and state encoding for the product accumulator.
// Saturating arithmetic is selected with PRODUCT_ACC_SAT_EN.
package product_accumulator_pkg;
    localparam int PROD_W = 12;
    localparam int CNT_W  = 8;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;
endpackage

// File: rtl/product_accumulator_acc_sat_adder.sv
// Accumulator adder: ACC_W-bit running sum plus one product.
// With PRODUCT_ACC_SAT_EN it clamps to all-ones and reports the carry, otherwise it wraps.
module acc_sat_adder
    import product_accumulator_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] addend,
`ifdef PRODUCT_ACC_SAT_EN
    output logic              ovf,
`endif
    output logic [ACC_W-1:0]  sum
);

`ifdef PRODUCT_ACC_SAT_EN
    logic [ACC_W:0] sum_full;

    assign sum_full = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, addend};
    assign ovf      = sum_full[ACC_W];
    assign sum      = ovf ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
`else
    assign sum = acc + {{(ACC_W - PROD_W){1'b0}}, addend};
`endif

endmodule

// File: rtl/product_accumulator.sv
// Groups up to N_TERMS products into one ACC_W-bit sum behind valid/ready ports.
// Define PRODUCT_ACC_SAT_EN for saturating sums with a sticky overflow flag on out_ovf.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [ACC_W-1:0]  out_data_q, out_data_d;
    logic [CNT_W-1:0]  out_count_q, out_count_d;
    logic [ACC_W-1:0]  sum;
    logic              accept;
    logic              closing;

`ifdef PRODUCT_ACC_SAT_EN
    logic add_ovf;
    logic grp_ovf;
    logic ovf_q, ovf_d;
    logic out_ovf_q, out_ovf_d;
`endif

    acc_sat_adder #(
        .ACC_W (ACC_W)
    ) u_adder (
        .acc    (acc_q),
        .addend (in_data),
`ifdef PRODUCT_ACC_SAT_EN
        .ovf    (add_ovf),
`endif
        .sum    (sum)
    );

    // in_ready is a registered copy of the state, so accepting never depends on out_ready
    assign accept  = in_valid && in_ready_q;
    assign closing = (cnt_q == LAST_CNT) || in_last;

`ifdef PRODUCT_ACC_SAT_EN
    assign grp_ovf = ovf_q | add_ovf;
`endif

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
`ifdef PRODUCT_ACC_SAT_EN
        ovf_d       = ovf_q;
        out_ovf_d   = out_ovf_q;
`endif
        case (state_q)
            ACC: begin
                if (accept) begin
                    if (closing) begin
                        out_data_d  = sum;
                        out_count_d = cnt_q + CNT_W'(1);
                        acc_d       = '0;
                        cnt_d       = '0;
                        state_d     = HOLD;
`ifdef PRODUCT_ACC_SAT_EN
                        out_ovf_d   = grp_ovf;
                        ovf_d       = 1'b0;
`endif
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + CNT_W'(1);
`ifdef PRODUCT_ACC_SAT_EN
                        ovf_d = grp_ovf;
`endif
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACC;
                end
            end
        endcase
        in_ready_d  = (state_d == ACC);
        out_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
`ifdef PRODUCT_ACC_SAT_EN
            ovf_q       <= 1'b0;
            out_ovf_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
`ifdef PRODUCT_ACC_SAT_EN
            ovf_q       <= ovf_d;
            out_ovf_q   <= out_ovf_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
`ifdef PRODUCT_ACC_SAT_EN
    assign out_ovf   = out_ovf_q;
`else
    assign out_ovf   = 1'b0;
`endif

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Sequential stage directly downstream of the 6-bit unsigned array multiplier. It consumes one 12-bit product per cycle through a valid/ready handshake and accumulates a group of up to N_TERMS products into a wider sum. It then presents the sum with its term count on an output valid/ready port. Together with the multiplier it forms a multiply-accumulate (dot-product) datapath.

## Interface
- N_TERMS, 4, maximum products per group; legal range 1 to 255.
- ACC_W, 16, accumulator and result width; must be 12 or more.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; synchronous, active-low, sampled on the rising edge of clk.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  12  unsigned product from the multiplier.
- in_last  input  1  the accepted term closes the group early; ignored unless in_valid and in_ready are both high.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_data  output  ACC_W  accumulated sum.
- out_count  output  8  number of terms in the group (1..N_TERMS).
- out_ovf  output  1  overflow occurred in the group (saturation build only).

## Operation
- Two states:
  - ACC: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Accept: in_valid && in_ready. Result: out_valid && out_ready.
- In ACC, on accept:
  - acc ← acc + zero-extended in_data.
  - cnt ← cnt + 1.
- Closing term: cnt == N_TERMS-1 at accept, or in_last=1.
  - out_data ← acc + in_data.
  - out_count ← cnt + 1.
  - out_ovf ← group overflow.
  - Then acc ← 0, cnt ← 0, state → HOLD.
- In HOLD, on result: state → ACC. out_data, out_count and out_ovf keep their values until the next close.
- Arithmetic is unsigned at ACC_W+1 bits. Carry out of bit ACC_W-1 is an overflow event; overflow is sticky within the group.
- in_valid with no accept changes no state.
- No empty groups: a group always holds at least 1 term.
- Reset value of every output: in_ready=0, out_valid=0, out_data=0, out_count=0, out_ovf=0.
- Reset state is ACC with acc=0, cnt=0, ovf=0. in_ready rises the first cycle after rst_n goes high.
- Reset mid-group or in HOLD discards the partial sum and any pending result.

## Timing
- Result latency: out_valid is high the cycle after the closing accept.
- Throughput: a group of k terms takes k accept cycles plus at least 1 HOLD cycle.
- No accept is possible in the cycle the result handshake completes; in_ready returns the next cycle.
- One bubble per group is intended.
- out_data, out_count and out_ovf are registered. They are stable while out_valid=1 and out_ready=0.
- in_ready depends only on state. It has no combinational path from out_ready or in_valid.

## Configuration
- PRODUCT_ACC_SAT_EN defined:
  - On overflow, acc clamps to 2^ACC_W-1 and stays there for the rest of the group.
  - The sticky ovf flag is reported on out_ovf.
- PRODUCT_ACC_SAT_EN undefined:
  - Sum wraps modulo 2^ACC_W.
  - out_ovf is tied to 0 and the ovf register is not built.

## Structure
- The shared package holds:
  - product width constant PROD_W=12.
  - count width constant CNT_W=8.
  - state enum {ACC, HOLD}.
- One natural sub-module: acc_sat_adder.
  - ACC_W-bit acc plus PROD_W-bit addend.
  - Outputs the sum and the overflow bit.
  - Clamps to all-ones when PRODUCT_ACC_SAT_EN is defined, wraps otherwise.

## Test plan
- Defaults, four terms of 4095, out_ready=1 → out_data=16380, out_count=4, out_ovf=0, out_valid exactly 1 cycle after the 4th accept.
- Terms 10, then 20 with in_last=1 → out_data=30, out_count=2. The next group starts from 0: term 5 with in_last → out_data=5, out_count=1.
- ACC_W=13, terms 4095, 4095, 4095 with in_last on the third:
  - Saturation build → 8191, ovf=1.
  - Wrap build → 4093, ovf=0.
- Closed group held with out_ready=0 for 5 cycles → out_data/out_count stable, in_ready=0, further in_valid ignored. out_ready=1 → in_ready=1 on the following cycle.
- Two terms accepted, then rst_n=0 for 1 cycle → all outputs 0. A subsequent group of 7,8,9,1 → out_data=25, out_count=4.
- in_valid toggling randomly with N_TERMS=1 → every accepted term emerges unmodified as out_data with out_count=1, in order, no loss or duplication.
